// File: rtl/pipe1_pkg.sv
// pipe1 shared definitions: state encodings, ex bit index, output bundle.
// Optional fetch AdEL detection is enabled with FETCH_ADEL_CHECK_EN.
package pipe1_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FRESH = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam int EX_ADEL_IF = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  ex;
  } if_id_t;

  function automatic logic adel_chk(logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pipe1_if.sv
// pipe1 handshake bundle: pipe0 fetch PC, inst RAM data, pipe2 output.
// master = upstream/downstream environment, slave = pipe1.
interface pipe1_if;
  logic        pipe0_valid;
  logic [31:0] pipe0_nextpc;
  logic [31:0] inst_ram_dout;
  logic        out_ready;
  logic        flush;
  logic        allowin;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [5:0]  ex_out;

  modport master (
    output pipe0_valid,
    output pipe0_nextpc,
    output inst_ram_dout,
    output out_ready,
    output flush,
    input  allowin,
    input  valid_out,
    input  pc_out,
    input  inst_out,
    input  ex_out
  );

  modport slave (
    input  pipe0_valid,
    input  pipe0_nextpc,
    input  inst_ram_dout,
    input  out_ready,
    input  flush,
    output allowin,
    output valid_out,
    output pc_out,
    output inst_out,
    output ex_out
  );
endinterface

// File: rtl/pipe1_inst_buf.sv
// pipe1 skid buffer: holds a stalled inst RAM word and muxes the
// instruction source by state (FRESH -> RAM, HELD -> buffer, EMPTY -> 0).
module pipe1_inst_buf
  import pipe1_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  state,
  input  logic        capture,
  input  logic [31:0] dout,
  output logic [31:0] inst
);

  logic [31:0] buf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q <= 32'h0;
    end else if (capture) begin
      buf_q <= dout;
    end
  end

  always_comb begin
    inst = 32'h0;
    unique case (1'b1)
      (state == ST_FRESH): inst = dout;
      (state == ST_HELD):  inst = buf_q;
      default:             inst = 32'h0;
    endcase
  end

endmodule

// File: rtl/pipe1.sv
// pipe1 fetch stage: registers the fetch PC, absorbs pipe2 stalls.
// Define FETCH_ADEL_CHECK_EN to flag misaligned fetch PCs (AdEL).
module pipe1
  import pipe1_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  pipe1_if.slave bus
);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] pc_q;
  logic [31:0] buf_inst;
  logic        allowin;
  logic        accept;
  logic        capture;
  logic        valid;
  if_id_t      ifo;

  assign allowin = bus.flush || (state == ST_EMPTY) || bus.out_ready;
  assign accept  = bus.pipe0_valid && allowin;
  assign valid   = (state != ST_EMPTY) && !bus.flush;
  assign capture = (state == ST_FRESH) && !bus.out_ready && !bus.flush;

  always_comb begin
    state_nx = ST_EMPTY;
    if (bus.flush) begin
      state_nx = accept ? ST_FRESH : ST_EMPTY;
    end else begin
      unique case (1'b1)
        (state == ST_EMPTY):
          state_nx = accept ? ST_FRESH : ST_EMPTY;
        (state == ST_FRESH),
        (state == ST_HELD):
          if (bus.out_ready)
            state_nx = accept ? ST_FRESH : ST_EMPTY;
          else
            state_nx = ST_HELD;
        default:
          state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_EMPTY;
      pc_q  <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) pc_q <= bus.pipe0_nextpc;
    end
  end

  pipe1_inst_buf u_buf (
    .clock   (clock),
    .reset   (reset),
    .state   (state),
    .capture (capture),
    .dout    (bus.inst_ram_dout),
    .inst    (buf_inst)
  );

`ifdef FETCH_ADEL_CHECK_EN
  logic       ex_q;
  logic [5:0] ex_v;

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q <= 1'b0;
    end else if (accept) begin
      ex_q <= adel_chk(bus.pipe0_nextpc[1:0]);
    end
  end

  always_comb begin
    ex_v = 6'b0;
    ex_v[EX_ADEL_IF] = ex_q && valid;
  end

  // A faulting fetch never presents a real instruction word.
  assign ifo = '{pc: pc_q, inst: ex_q ? 32'h0 : buf_inst, ex: ex_v};
`else
  assign ifo = '{pc: pc_q, inst: buf_inst, ex: 6'b0};
`endif

  assign bus.allowin   = allowin;
  assign bus.valid_out = valid;
  assign bus.pc_out    = ifo.pc;
  assign bus.inst_out  = ifo.inst;
  assign bus.ex_out    = ifo.ex;

endmodule

// File: tb/tb_pipe1.sv
// Directed testbench for pipe1: streaming, stall, flush, reset, AdEL.
// Expected values are hand-computed per vector.
module tb_pipe1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pipe1_if bus();

  pipe1 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] dout, input logic rdy,
                       input logic fl);
    bus.pipe0_valid   = v;
    bus.pipe0_nextpc  = pc;
    bus.inst_ram_dout = dout;
    bus.out_ready     = rdy;
    bus.flush         = fl;
    #1;
  endtask

  initial begin
    drive(1'b1, 32'hBFC0_0000, 32'h0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    // reset held with pipe0_valid=1: no accept
    chk("rst_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_inst", bus.inst_out, 32'h0);
    chk("rst_allowin", {31'b0, bus.allowin}, 32'd1);
    chk("rst_ex", {26'b0, bus.ex_out}, 32'd0);

    // streaming
    reset = 1'b0;
    drive(1'b1, 32'hBFC0_0000, 32'h0, 1'b1, 1'b0);
    chk("st0_valid", {31'b0, bus.valid_out}, 32'd0);
    tick();
    drive(1'b1, 32'hBFC0_0004, 32'h3C08_BFC0, 1'b1, 1'b0);
    chk("st1_valid", {31'b0, bus.valid_out}, 32'd1);
    chk("st1_pc", bus.pc_out, 32'hBFC0_0000);
    chk("st1_inst", bus.inst_out, 32'h3C08_BFC0);
    tick();
    drive(1'b1, 32'hBFC0_0008, 32'h3508_0010, 1'b1, 1'b0);
    chk("st2_valid", {31'b0, bus.valid_out}, 32'd1);
    chk("st2_pc", bus.pc_out, 32'hBFC0_0004);
    chk("st2_inst", bus.inst_out, 32'h3508_0010);
    tick();
    drive(1'b0, 32'h0, 32'h0000_0000, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h2408_0005, 1'b1, 1'b0);
    chk("st3_valid", {31'b0, bus.valid_out}, 32'd1);
    chk("st3_pc", bus.pc_out, 32'hBFC0_0008);
    chk("st3_inst", bus.inst_out, 32'h2408_0005);
    tick();
    chk("st4_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("st4_inst", bus.inst_out, 32'h0);

    // EMPTY with out_ready=0 still accepts
    drive(1'b1, 32'hBFC0_0010, 32'h0, 1'b0, 1'b0);
    chk("em_allowin", {31'b0, bus.allowin}, 32'd1);
    tick();
    // stall: FRESH then 3 cycles out_ready=0
    drive(1'b1, 32'hBFC0_0014, 32'h2408_0001, 1'b0, 1'b0);
    chk("sf_valid", {31'b0, bus.valid_out}, 32'd1);
    chk("sf_inst", bus.inst_out, 32'h2408_0001);
    chk("sf_allowin", {31'b0, bus.allowin}, 32'd0);
    tick();
    drive(1'b1, 32'hBFC0_0014, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("sh1_inst", bus.inst_out, 32'h2408_0001);
    chk("sh1_pc", bus.pc_out, 32'hBFC0_0010);
    chk("sh1_allowin", {31'b0, bus.allowin}, 32'd0);
    tick();
    drive(1'b1, 32'hBFC0_0014, 32'h1111_1111, 1'b0, 1'b0);
    chk("sh2_inst", bus.inst_out, 32'h2408_0001);
    chk("sh2_pc", bus.pc_out, 32'hBFC0_0010);
    tick();
    drive(1'b1, 32'hBFC0_0014, 32'h2222_2222, 1'b1, 1'b0);
    chk("rel_valid", {31'b0, bus.valid_out}, 32'd1);
    chk("rel_inst", bus.inst_out, 32'h2408_0001);
    chk("rel_allowin", {31'b0, bus.allowin}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h2409_0002, 1'b1, 1'b0);
    chk("nx_pc", bus.pc_out, 32'hBFC0_0014);
    chk("nx_inst", bus.inst_out, 32'h2409_0002);
    tick();
    chk("nx_empty", {31'b0, bus.valid_out}, 32'd0);

    // flush in HELD with redirect
    drive(1'b1, 32'hBFC0_0020, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'hAAAA_0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hBFC0_0380, 32'h0, 1'b0, 1'b1);
    chk("fl_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("fl_allowin", {31'b0, bus.allowin}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h4080_6000, 1'b1, 1'b0);
    chk("fl_nvalid", {31'b0, bus.valid_out}, 32'd1);
    chk("fl_npc", bus.pc_out, 32'hBFC0_0380);
    chk("fl_ninst", bus.inst_out, 32'h4080_6000);
    tick();
    chk("fl_empty", {31'b0, bus.valid_out}, 32'd0);

    // reset mid-stall
    drive(1'b1, 32'hBFC0_0030, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h5555_0000, 1'b0, 1'b0);
    tick();
    chk("rh_held", {31'b0, bus.allowin}, 32'd0);
    reset = 1'b1;
    drive(1'b1, 32'hBFC0_0040, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rh_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("rh_pc", bus.pc_out, 32'h0);
    chk("rh_allowin", {31'b0, bus.allowin}, 32'd1);
    chk("rh_inst", bus.inst_out, 32'h0);

    // misaligned fetch PC
    drive(1'b1, 32'hBFC0_0002, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h1234_5678, 1'b1, 1'b0);
    chk("ad_valid", {31'b0, bus.valid_out}, 32'd1);
    chk("ad_pc", bus.pc_out, 32'hBFC0_0002);
`ifdef FETCH_ADEL_CHECK_EN
    chk("ad_ex", {26'b0, bus.ex_out}, 32'd1);
    chk("ad_inst", bus.inst_out, 32'h0);
`else
    chk("ad_ex", {26'b0, bus.ex_out}, 32'd0);
    chk("ad_inst", bus.inst_out, 32'h1234_5678);
`endif
    tick();
    chk("ad_exempty", {26'b0, bus.ex_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe1.md
PIPE1 -- requirements
Module: pipe1

Interface
REQ-001 SHALL have ports: clock  input  1  system clock.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: pipe0_valid  input  1  pipe0 holds a valid fetch PC this cycle.
REQ-004 SHALL have ports: pipe0_nextpc  input  32  virtual PC whose address pipe0 drives to inst RAM this cycle.
REQ-005 SHALL have ports: inst_ram_dout  input  32  sync inst RAM read data, valid one cycle after the address.
REQ-006 SHALL have ports: out_ready  input  1  pipe2 accepts the current instruction this cycle.
REQ-007 SHALL have ports: flush  input  1  exception/ERET redirect from pipe5.
REQ-008 SHALL have ports: allowin  output  1  to pipe0 nextpc_en; pipe1 accepts a PC this cycle.
REQ-009 SHALL have ports: valid_out  output  1  pc_out/inst_out/ex_out valid to pipe2.
REQ-010 SHALL have ports: pc_out  output  32  PC of the held instruction.
REQ-011 SHALL have ports: inst_out  output  32  fetched instruction word.
REQ-012 SHALL have ports: ex_out  output  6  fetch exception flags; bit0 = AdEL (fetch), bits5:1 = 0.

Function
REQ-013 SHALL define accept = pipe0_valid && allowin; allowin = flush || (state==EMPTY) || out_ready.
REQ-014 SHALL implement three states: EMPTY (no instruction), FRESH (instruction on inst_ram_dout), HELD (instruction in internal buffer).
REQ-015 SHALL latch pc_out <= pipe0_nextpc on accept; latency address-to-valid_out is one cycle.
REQ-016 SHALL transition EMPTY -> FRESH on accept, else stay EMPTY.
REQ-017 SHALL transition FRESH/HELD with out_ready: accept -> FRESH, no accept -> EMPTY.
REQ-018 SHALL transition FRESH with !out_ready -> HELD, capturing inst_ram_dout into the buffer that cycle.
REQ-019 SHALL stay in HELD with !out_ready, buffer and pc_out unchanged.
REQ-020 SHALL drive inst_out = buffer in HELD, inst_ram_dout in FRESH, 32'h0 in EMPTY.
REQ-021 SHALL drive valid_out = (state != EMPTY) && !flush.
REQ-022 SHALL give flush priority over out_ready: current instruction discarded, state -> FRESH if pipe0_valid (redirect PC accepted same cycle), else EMPTY.
REQ-023 SHALL never drop or duplicate an instruction: each accepted PC reaches pipe2 exactly once unless flushed.
REQ-024 SHALL keep ex_out = 0 whenever valid_out = 0.

Reset
REQ-025 SHALL on reset set state EMPTY, pc_out 32'h0, buffer 32'h0, ex flag 0; valid_out 0, inst_out 0, allowin 1.
REQ-026 SHALL let reset override flush and accept in the same cycle; no accept occurs during reset.

Configuration
REQ-027 SHALL, with FETCH_ADEL_CHECK_EN defined, register ex_out[0] = (pipe0_nextpc[1:0] != 0) on accept, and force inst_out = 32'h0 while that flag is set.
REQ-028 SHALL, without FETCH_ADEL_CHECK_EN, tie ex_out to 6'b0 and omit the check logic.

Structure
REQ-029 SHALL take state encodings (EMPTY/FRESH/HELD, 2 bits) and ex bit index EX_ADEL_IF from the shared pipeline package.
REQ-030 SHALL implement the buffer and FRESH/HELD output mux as sub-module pipe1_inst_buf.

Verification
REQ-031 SHALL test streaming: pipe0_valid=1, out_ready=1, PCs 0xBFC00000/04/08 -> valid_out each cycle from cycle 1, pc_out/inst_out in order, never HELD.
REQ-032 SHALL test stall: FRESH with inst 0x24080001, out_ready=0 for 3 cycles while dout changes -> inst_out stays 0x24080001, allowin=0, then released exactly once.
REQ-033 SHALL test flush in HELD with pipe0_valid=1, pipe0_nextpc=0xBFC00380 -> next cycle FRESH, pc_out=0xBFC00380, stalled instruction never valid_out.
REQ-034 SHALL test reset mid-stall (HELD) -> next cycle valid_out=0, pc_out=0, allowin=1.
REQ-035 SHALL test FETCH_ADEL_CHECK_EN: accept pc 0xBFC00002 -> ex_out=6'b000001, inst_out=0; without macro ex_out=0.
REQ-036 SHALL test EMPTY with out_ready=0 and pipe0_valid=1 -> accept occurs (allowin=1), state FRESH.
